// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types for the cacheline-to-burst adaptor: widths, line/beat types and FSM states.
package cacheline_burst_adaptor_pkg;
  localparam int LINE_WIDTH = 256;
  localparam int BEAT_WIDTH = 64;

  typedef logic [LINE_WIDTH-1:0] cacheline_t;
  typedef logic [BEAT_WIDTH-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_e;
endpackage

// File: rtl/cacheline_burst_adaptor.sv
// Splits one cacheline read/write into a BEATS-long burst on a narrow memory bus and
// reassembles read beats into a full line; one transaction in flight at a time.
module cacheline_burst_adaptor
  import cacheline_burst_adaptor_pkg::*;
#(
  parameter int LINE_WIDTH = cacheline_burst_adaptor_pkg::LINE_WIDTH,
  parameter int BEAT_WIDTH = cacheline_burst_adaptor_pkg::BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           line_addr_i,
  input  logic                  line_read_i,
  input  logic                  line_write_i,
  input  logic [LINE_WIDTH-1:0] line_wdata_i,
  output logic [LINE_WIDTH-1:0] line_rdata_o,
  output logic                  line_resp_o,
  output logic [31:0]           mem_addr_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [BEAT_WIDTH-1:0] mem_wdata_o,
  input  logic [BEAT_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_resp_i
);
  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CW    = $clog2(BEATS);
  localparam int OFS   = $clog2(LINE_WIDTH / 8);
  localparam logic [CW-1:0] LAST      = CW'(BEATS - 1);
  localparam logic [31:0]   ADDR_MASK = ~((32'd1 << OFS) - 32'd1);

  adaptor_state_e        state_q;
  logic [CW-1:0]         cnt_q;
  logic [31:0]           addr_q;
  logic [LINE_WIDTH-1:0] wline_q;
  logic [LINE_WIDTH-1:0] rline_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Write has priority if the cache ever raises both requests.
          if (line_write_i) begin
            addr_q  <= line_addr_i & ADDR_MASK;
            wline_q <= line_wdata_i;
            state_q <= WRITE;
          end else if (line_read_i) begin
            addr_q  <= line_addr_i & ADDR_MASK;
            state_q <= READ;
          end
        end
        READ: begin
          if (mem_resp_i) begin
            rline_q[BEAT_WIDTH*cnt_q +: BEAT_WIDTH] <= mem_rdata_i;
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        WRITE: begin
          if (mem_resp_i) begin
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory-side outputs decode straight from the state register so reset clears them at once.
  assign mem_read_o   = (state_q == READ);
  assign mem_write_o  = (state_q == WRITE);
  assign mem_addr_o   = (state_q == READ || state_q == WRITE) ? addr_q : '0;
  assign mem_wdata_o  = (state_q == WRITE) ? wline_q[BEAT_WIDTH*cnt_q +: BEAT_WIDTH] : '0;
  assign line_resp_o  = (state_q == DONE);
  assign line_rdata_o = rline_q;
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Randomised bench: a memory model indexed by beat address supplies read beats and
// records write beats; each transaction is checked for data, address, latency and pulse width.
module tb_cacheline_burst_adaptor;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  line_addr_i;
  logic         line_read_i, line_write_i;
  logic [255:0] line_wdata_i, line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  mem_addr_o;
  logic         mem_read_o, mem_write_o;
  logic [63:0]  mem_wdata_o, mem_rdata_i;
  logic         mem_resp_i;

  int checks = 0;
  int errors = 0;
  logic [63:0]  mem_m [logic [31:0]];
  logic [255:0] last_rd;

  cacheline_burst_adaptor dut (
    .clk(clk), .rst_n(rst_n),
    .line_addr_i(line_addr_i), .line_read_i(line_read_i), .line_write_i(line_write_i),
    .line_wdata_i(line_wdata_i), .line_rdata_o(line_rdata_o), .line_resp_o(line_resp_o),
    .mem_addr_o(mem_addr_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_idle_outputs(input string nm);
    checks++;
    if ({mem_read_o, mem_write_o, line_resp_o} !== 3'b000 || mem_addr_o !== 32'h0 || mem_wdata_o !== 64'h0) begin
      errors++;
      $display("FAIL %s: rd=%b wr=%b resp=%b addr=%h wdata=%h, all required 0", nm,
               mem_read_o, mem_write_o, line_resp_o, mem_addr_o, mem_wdata_o);
    end
  endtask

  // One full cache transaction. Beat i is returned on active cycle lat+i (+gap_len once i>=gap_at).
  task automatic do_txn(input bit wr, input bit both, input logic [31:0] addr,
                        input logic [255:0] wline, input int lat, input int gap_at,
                        input int gap_len, input string nm);
    logic [31:0]  base;
    logic [255:0] exp_line;
    int bi, act, cyc, gap;
    bit started, done;
    base = addr & 32'hFFFF_FFE0;
    gap  = (gap_at < 4) ? gap_len : 0;
    for (int i = 0; i < 4; i++) begin
      if (!wr) begin
        if (!mem_m.exists(base + 32'(8*i))) mem_m[base + 32'(8*i)] = {$urandom, $urandom};
        exp_line[64*i +: 64] = mem_m[base + 32'(8*i)];
      end else begin
        exp_line[64*i +: 64] = wline[64*i +: 64];
      end
    end
    bi = 0; act = 0; cyc = 1; started = 0; done = 0;
    line_addr_i  = addr;
    line_wdata_i = wline;
    line_write_i = wr;
    line_read_i  = !wr || both;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      mem_resp_i  = 1'b0;
      mem_rdata_i = {$urandom, $urandom};
      if (line_resp_o) begin
        done = 1;
        line_read_i  = 1'b0;
        line_write_i = 1'b0;
        checks++;
        if (cyc !== 1 + lat + 4 + gap + 1) begin
          errors++;
          $display("FAIL %s latency: got %0d cycles, required %0d", nm, cyc, 1 + lat + 4 + gap + 1);
        end
        checks++;
        if (mem_read_o !== 1'b0 || mem_write_o !== 1'b0) begin
          errors++;
          $display("FAIL %s done_cycle: rd=%b wr=%b, required 0 0", nm, mem_read_o, mem_write_o);
        end
        checks++;
        if (line_rdata_o !== (wr ? last_rd : exp_line)) begin
          errors++;
          $display("FAIL %s line: got %h required %h", nm, line_rdata_o, wr ? last_rd : exp_line);
        end
      end else if (mem_read_o || mem_write_o) begin
        if (!started) begin
          started = 1;
          // Inputs are only sampled at accept; scramble them to prove it.
          line_addr_i  = $urandom;
          line_wdata_i = rand_line();
        end
        checks++;
        if (mem_read_o !== !wr || mem_write_o !== wr || mem_addr_o !== base) begin
          errors++;
          $display("FAIL %s burst: rd=%b wr=%b addr=%h, required rd=%b wr=%b addr=%h",
                   nm, mem_read_o, mem_write_o, mem_addr_o, !wr, wr, base);
        end
        if (bi < 4 && act == lat + bi + ((bi >= gap_at) ? gap_len : 0)) begin
          mem_resp_i = 1'b1;
          if (wr) begin
            checks++;
            if (mem_wdata_o !== wline[64*bi +: 64]) begin
              errors++;
              $display("FAIL %s wbeat%0d: got %h required %h", nm, bi, mem_wdata_o, wline[64*bi +: 64]);
            end
            mem_m[base + 32'(8*bi)] = wline[64*bi +: 64];
          end else begin
            mem_rdata_i = exp_line[64*bi +: 64];
          end
          bi++;
        end
        act++;
      end else if (started) begin
        errors++; checks++;
        $display("FAIL %s burst_dropped: request fell at beat %0d before line_resp_o", nm, bi);
        done = 1;
      end
    end
    mem_resp_i   = 1'b0;
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    if (!done) begin
      errors++; checks++;
      $display("FAIL %s timeout: no line_resp_o after %0d cycles", nm, cyc);
    end
    @(negedge clk);
    checks++;
    if (line_resp_o !== 1'b0 || mem_read_o !== 1'b0 || mem_write_o !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: resp=%b rd=%b wr=%b, required 0 0 0", nm, line_resp_o, mem_read_o, mem_write_o);
    end
    if (!wr) last_rd = exp_line;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    line_addr_i = '0; line_read_i = 0; line_write_i = 0; line_wdata_i = '0;
    mem_rdata_i = '0; mem_resp_i = 0;
    #12;
    check_idle_outputs("reset");
    checks++;
    if (line_rdata_o !== 256'h0) begin
      errors++; $display("FAIL reset_rdata: got %h required 0", line_rdata_o);
    end
    @(negedge clk); rst_n = 1'b1;
    // Stray beat strobes in IDLE must be ignored.
    mem_resp_i = 1'b1; mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk); mem_resp_i = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle_stray_resp");
    checks++;
    if (line_rdata_o !== 256'h0) begin
      errors++; $display("FAIL idle_stray_rdata: got %h required 0", line_rdata_o);
    end
    last_rd = '0;
  endtask

  task automatic test_read_latency();
    for (int i = 0; i < 4; i++) mem_m[32'h1220 + 32'(8*i)] = 64'h1111_1111_1111_1111 * (i + 1);
    do_txn(0, 0, 32'h0000_1234, '0, 10, 4, 0, "read_lat10");
    checks++;
    if (last_rd !== {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}) begin
      errors++; $display("FAIL read_lat10 pattern: got %h", last_rd);
    end
  endtask

  task automatic test_write();
    do_txn(1, 0, 32'h8000_00E0, {64'hD, 64'hC, 64'hB, 64'hA}, 0, 4, 0, "write_abcd");
  endtask

  task automatic test_read_gap();
    do_txn(0, 0, 32'h0000_4040, '0, 0, 2, 3, "read_gap");
    do_txn(0, 0, 32'h0000_5000, '0, 2, 1, 2, "read_gap2");
  endtask

  task automatic test_both_high();
    $display("note: line_read_i and line_write_i raised together (cache protocol violation)");
    do_txn(1, 1, 32'h0000_7000, rand_line(), 1, 4, 0, "both_high");
  endtask

  task automatic test_reset_midburst();
    int beats = 0;
    line_addr_i = 32'h0000_9000; line_read_i = 1'b1;
    for (int c = 0; c < 20 && beats < 3; c++) begin
      @(negedge clk);
      mem_resp_i = mem_read_o;
      mem_rdata_i = {$urandom, $urandom};
      if (mem_read_o) beats++;
    end
    @(negedge clk);
    mem_resp_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midburst_reset");
    checks++;
    if (line_rdata_o !== 256'h0) begin
      errors++; $display("FAIL midburst_reset_rdata: got %h required 0", line_rdata_o);
    end
    line_read_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    last_rd = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (line_resp_o !== 1'b0) begin
        errors++; $display("FAIL midburst_no_resp: got %b required 0", line_resp_o);
      end
    end
    do_txn(0, 0, 32'h0000_A01C, '0, 1, 4, 0, "read_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0]  a;
    logic [255:0] l;
    a = $urandom;
    l = rand_line();
    do_txn(1, 0, a, l, 0, 4, 0, "b2b_write");
    do_txn(0, 0, a, '0, 0, 4, 0, "b2b_read");
    checks++;
    if (last_rd !== l) begin
      errors++; $display("FAIL b2b_readback: got %h required %h", last_rd, l);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      // Reuse a small address pool so reads often hit previously written lines.
      do_txn($urandom_range(0, 1), 0, {24'h0, 8'($urandom_range(0, 7) << 5)} | 32'($urandom_range(0, 31)),
             rand_line(), $urandom_range(0, 4), $urandom_range(1, 4), $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write();
    test_read_gap();
    test_both_high();
    test_reset_midburst();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
